// File: rtl/memory_cycle.sv
// Memory stage of the RV32 pipeline: word-addressed data memory plus the M/W pipeline register.
// Loads read combinationally and are captured into ReadDataW, so a load reaches W one cycle later.
module memory_cycle #(
  parameter int DMEM_WORDS = 1024,
  parameter int ADDR_BITS  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW
);

  // Every word is cleared asynchronously on reset, so the array is built from
  // resettable registers rather than a RAM macro.
  logic [31:0] mem_reg [DMEM_WORDS];

  logic [ADDR_BITS-1:0] word_index;
  logic [31:0]          read_word;

  // Byte-offset bits and bits above the array are dropped, so accesses wrap.
  assign word_index = ALU_ResultM[ADDR_BITS+1:2];
  assign read_word  = mem_reg[word_index];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        mem_reg[i] <= 32'h0;
      end
    end else if (MemWriteM) begin
      mem_reg[word_index] <= WriteDataM;
    end
  end

  // ReadDataW samples the pre-write contents, giving read-before-write on a
  // same-edge load/store to one word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= 5'd0;
      PCPlus4W    <= 32'h0;
      ALU_ResultW <= 32'h0;
      ReadDataW   <= 32'h0;
    end else begin
      RegWriteW   <= RegWriteM;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= read_word;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: reset, store/load, pass-through, read-before-write,
// aliasing, back-to-back stores and mid-run reset, with hand-computed expectations.
module tb_memory_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M;
  logic [31:0] WriteDataM;
  logic [31:0] ALU_ResultM;
  logic        RegWriteW;
  logic        ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;

  int checks = 0;
  int errors = 0;

  memory_cycle #(.DMEM_WORDS(1024), .ADDR_BITS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .RD_M       (RD_M),
    .PCPlus4M   (PCPlus4M),
    .WriteDataM (WriteDataM),
    .ALU_ResultM(ALU_ResultM),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .RD_W       (RD_W),
    .PCPlus4W   (PCPlus4W),
    .ALU_ResultW(ALU_ResultW),
    .ReadDataW  (ReadDataW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Present one M-stage transaction at the falling edge, then sample 1 ns after the rising edge.
  task automatic step(input logic regw, input logic memw, input logic rsrc, input logic [4:0] rd,
                      input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] alu);
    @(negedge clk);
    RegWriteM   = regw;
    MemWriteM   = memw;
    ResultSrcM  = rsrc;
    RD_M        = rd;
    PCPlus4M    = pc;
    WriteDataM  = wd;
    ALU_ResultM = alu;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] addr);
    step(1'b1, 1'b0, 1'b1, 5'd1, 32'h4, 32'h0, addr);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    step(1'b0, 1'b1, 1'b0, 5'd0, 32'h8, data, addr);
  endtask

  initial begin
    rst = 1'b0;
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RD_M = 0;
    PCPlus4M = 0; WriteDataM = 0; ALU_ResultM = 0;

    // Reset held with random inputs (including stores) over several edges.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      RegWriteM   = 1'b1;
      MemWriteM   = 1'b1;
      ResultSrcM  = 1'b1;
      RD_M        = 5'($urandom);
      PCPlus4M    = $urandom | 32'h1;
      WriteDataM  = $urandom | 32'h1;
      ALU_ResultM = 32'h0000_0100 + 32'(i * 4);
    end
    #1;
    check("rst_regwrite", {31'b0, RegWriteW}, 32'h0);
    check("rst_resultsrc", {31'b0, ResultSrcW}, 32'h0);
    check("rst_rd", {27'b0, RD_W}, 32'h0);
    check("rst_pcplus4", PCPlus4W, 32'h0);
    check("rst_aluresult", ALU_ResultW, 32'h0);
    check("rst_readdata", ReadDataW, 32'h0);
    @(negedge clk);
    MemWriteM = 1'b0;
    rst = 1'b1;

    load(32'h0000_0104);
    check("post_rst_load_0x104", ReadDataW, 32'h0);
    load(32'h0000_010C);
    check("post_rst_load_0x10c", ReadDataW, 32'h0);

    // Store then load.
    store(32'h1000_0040, 32'hABCD_EF01);
    load(32'h1000_0040);
    check("sw_lw_data", ReadDataW, 32'hABCD_EF01);
    check("sw_lw_resultsrc", {31'b0, ResultSrcW}, 32'h1);

    // Pass-through with no store.
    step(1'b1, 1'b0, 1'b0, 5'd7, 32'h24, 32'hDEAD_BEEF, 32'h6);
    check("pt_regwrite", {31'b0, RegWriteW}, 32'h1);
    check("pt_rd", {27'b0, RD_W}, 32'h7);
    check("pt_aluresult", ALU_ResultW, 32'h6);
    check("pt_pcplus4", PCPlus4W, 32'h24);
    check("pt_resultsrc", {31'b0, ResultSrcW}, 32'h0);
    check("pt_readdata_word1", ReadDataW, 32'h0);
    load(32'h1000_0040);
    check("pt_mem_unchanged", ReadDataW, 32'hABCD_EF01);

    // Read-before-write on the same word.
    store(32'h0000_0040, 32'h1111_1111);
    store(32'h0000_0040, 32'h2222_2222);
    check("rbw_old", ReadDataW, 32'h1111_1111);
    load(32'h0000_0040);
    check("rbw_new", ReadDataW, 32'h2222_2222);

    // Misaligned and out-of-range aliasing.
    store(32'h0000_0043, 32'h5A5A_5A5A);
    load(32'h0000_0040);
    check("alias_aligned", ReadDataW, 32'h5A5A_5A5A);
    load(32'h0000_1040);
    check("alias_wrap", ReadDataW, 32'h5A5A_5A5A);
    load(32'h0000_0044);
    check("alias_neighbour", ReadDataW, 32'h0);
    load(32'h0000_0FFC);
    check("top_word_empty", ReadDataW, 32'h0);

    // Back-to-back stores: each lands in its own cycle, last wins.
    store(32'h0000_0080, 32'hAAAA_0001);
    store(32'h0000_0080, 32'hBBBB_0002);
    check("b2b_first_visible", ReadDataW, 32'hAAAA_0001);
    load(32'h0000_0080);
    check("b2b_last_wins", ReadDataW, 32'hBBBB_0002);

    // Mid-run reset pulse between edges.
    step(1'b1, 1'b1, 1'b1, 5'd3, 32'h100, 32'hCAFE_BABE, 32'h0000_0200);
    load(32'h0000_0200);
    check("pre_rst_cafe", ReadDataW, 32'hCAFE_BABE);
    #2;
    rst = 1'b0;
    #3;
    check("mid_rst_regwrite", {31'b0, RegWriteW}, 32'h0);
    check("mid_rst_resultsrc", {31'b0, ResultSrcW}, 32'h0);
    check("mid_rst_rd", {27'b0, RD_W}, 32'h0);
    check("mid_rst_pcplus4", PCPlus4W, 32'h0);
    check("mid_rst_aluresult", ALU_ResultW, 32'h0);
    check("mid_rst_readdata", ReadDataW, 32'h0);
    rst = 1'b1;
    load(32'h0000_0200);
    check("mid_rst_mem_cleared", ReadDataW, 32'h0);
    check("first_edge_after_rst", ALU_ResultW, 32'h0000_0200);

    // Store presented while reset is asserted is discarded.
    @(negedge clk);
    rst         = 1'b0;
    MemWriteM   = 1'b1;
    WriteDataM  = 32'h1234_5678;
    ALU_ResultM = 32'h0000_0300;
    @(posedge clk);
    #1;
    rst = 1'b1;
    load(32'h0000_0300);
    check("store_during_rst_dropped", ReadDataW, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000 ns");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
